// File: rtl/streaming_in.sv
// streaming_in: serial-to-parallel receiver for the single-wire byte stream
// from the serial streaming output stage. Frame is start(1), marker(0),
// then d7..d0 MSB first. The received byte is presented on a one-entry
// valid/ready holding register. Framing and overrun errors are flagged.
// Runs on the serializer's clock, so sIn needs no synchronizer.
module streaming_in (
    input  logic       clk,
    input  logic       rst,
    input  logic       sIn,
    input  logic       outReady,
    output logic [7:0] dOut,
    output logic       outValid,
    output logic       frameErr,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [7:0] shift;

    // Decoded per-cycle events, shared by the FSM and the datapath
    logic       byte_done;
    logic [7:0] byte_nxt;
    logic       drain;
    logic       mark_err;
    logic       mark_ok;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples the values from before this edge.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a 1 in MARK is taken as a fresh start bit
    always_comb begin
        // NOTE: a default first keeps every path assigned, so no latch is
        // inferred when a case arm leaves the state untouched.
        state_nxt = state;
        case (state)
            IDLE:    if (sIn)        state_nxt = MARK;
            MARK:    if (!sIn)       state_nxt = DATA;
            DATA:    if (cnt == 3'd0) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Output decode: events that drive the counter, shifter and holding register
    always_comb begin
        mark_ok   = (state == MARK) && !sIn;
        mark_err  = (state == MARK) && sIn;
        byte_done = (state == DATA) && (cnt == 3'd0);
        byte_nxt  = {shift[6:0], sIn};
        drain     = outValid && outReady;
    end

    // Datapath: bit counter, shift register, holding register and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 3'd0;
            shift    <= 8'h00;
            dOut     <= 8'h00;
            outValid <= 1'b0;
            frameErr <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            frameErr <= mark_err;

            if (mark_ok) begin
                cnt <= 3'd7;
            end else if (state == DATA) begin
                cnt <= cnt - 3'd1;
            end

            if (state == DATA) begin
                shift <= byte_nxt;
            end

            // A completing byte wins the slot if the slot is empty or is
            // being drained this same edge; otherwise the new byte is lost.
            if (byte_done) begin
                if (!outValid || drain) begin
                    dOut     <= byte_nxt;
                    outValid <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (drain) begin
                outValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_streaming_in.sv
// Testbench for streaming_in: table-driven per-edge vectors for the single
// byte and framing-error cases, hand-written sequences for back-to-back,
// overrun, same-edge drain, mid-frame reset and idle line.
module tb_streaming_in;

    logic       clk = 1'b0;
    logic       rst;
    logic       sIn;
    logic       outReady;
    logic [7:0] dOut;
    logic       outValid;
    logic       frameErr;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    streaming_in dut (
        .clk      (clk),
        .rst      (rst),
        .sIn      (sIn),
        .outReady (outReady),
        .dOut     (dOut),
        .outValid (outValid),
        .frameErr (frameErr),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       s;
        logic       rdy;
        logic [7:0] d;
        logic       v;
        logic       fe;
        logic       ov;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic s, input logic rdy,
                                input logic [7:0] d, input logic v,
                                input logic fe, input logic ov);
        vec_t t;
        t.r = r; t.s = s; t.rdy = rdy; t.d = d; t.v = v; t.fe = fe; t.ov = ov;
        return t;
    endfunction

    // Advance one rising edge, then settle away from it before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] d, input logic v,
                             input logic fe, input logic ov);
        check({tag, ".dOut"},     dOut,          d);
        check({tag, ".outValid"}, 8'(outValid),  8'(v));
        check({tag, ".frameErr"}, 8'(frameErr),  8'(fe));
        check({tag, ".overrun"},  8'(overrun),   8'(ov));
    endtask

    task automatic do_reset();
        rst = 1'b1; sIn = 1'b0; outReady = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Drive one full frame; outReady is rdy_body on the first nine edges and
    // rdy_last on the d0 edge
    task automatic send_frame(input logic [7:0] b, input logic rdy_body, input logic rdy_last);
        logic [9:0] bits;
        bits = {2'b10, b};
        for (int i = 9; i >= 0; i--) begin
            rst      = 1'b0;
            sIn      = bits[i];
            outReady = (i == 0) ? rdy_last : rdy_body;
            tick();
        end
        sIn = 1'b0;
        outReady = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sIn = 1'b0; outReady = 1'b0;

        // ---- Table: reset, single byte 0xA5, drain, framing error + 0xFF
        //                r  s  rdy  dOut  v  fe ov
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0)); // start
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0)); // marker
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0)); // d7
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'hA5, 1, 0, 0)); // d0: byte complete
        tbl.push_back(mk(0, 0, 0, 8'hA5, 1, 0, 0)); // held without ready
        tbl.push_back(mk(0, 0, 0, 8'hA5, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'hA5, 0, 0, 0)); // drained
        tbl.push_back(mk(0, 0, 1, 8'hA5, 0, 0, 0)); // ready while empty: no effect
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0)); // reset
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0)); // start
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0)); // bad marker -> pulse
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0)); // marker ok, pulse ends
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'hFF, 1, 0, 0)); // 11th edge: 0xFF delivered

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; sIn = tbl[i].s; outReady = tbl[i].rdy;
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].d, tbl[i].v, tbl[i].fe, tbl[i].ov);
        end

        // ---- Back-to-back frames, ready throughout
        do_reset();
        send_frame(8'h3C, 1'b1, 1'b1);
        check_all("b2b_first", 8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b1);
        check_all("b2b_second", 8'hC3, 1'b1, 1'b0, 1'b0);

        // ---- Overrun: second byte dropped, flag sticky until reset
        do_reset();
        send_frame(8'h11, 1'b0, 1'b0);
        check_all("ovr_first", 8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        check_all("ovr_second", 8'h11, 1'b1, 1'b0, 1'b1);
        outReady = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        outReady = 1'b0;
        check_all("ovr_sticky", 8'h11, 1'b0, 1'b0, 1'b1);
        do_reset();
        #0;
        check_all("ovr_reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // ---- Same-edge completion and drain
        do_reset();
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1);
        check_all("same_edge", 8'h22, 1'b1, 1'b0, 1'b0);

        // ---- Reset after d4 of a 0x5A frame
        do_reset();
        begin
            logic [5:0] part;
            part = 6'b10_0101; // start, marker, d7..d4 of 0x5A
            for (int i = 5; i >= 0; i--) begin
                sIn = part[i];
                tick();
            end
        end
        rst = 1'b1; sIn = 1'b1; // d3 of 0x5A, ignored under reset
        tick();
        rst = 1'b0; sIn = 1'b0;
        check_all("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check_all("midrst_nobyte", 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b0);
        check_all("midrst_next", 8'h81, 1'b1, 1'b0, 1'b0);

        // ---- Idle line for 50 cycles, then a frame lands on schedule
        do_reset();
        begin
            int idle_bad;
            idle_bad = 0;
            for (int i = 0; i < 50; i++) begin
                sIn = 1'b0;
                tick();
                if (outValid || frameErr || overrun) idle_bad++;
            end
            check("idle_events", 8'(idle_bad), 8'd0);
        end
        send_frame(8'h96, 1'b0, 1'b0);
        check_all("idle_then_frame", 8'h96, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
